// File: rtl/mmcm_drp_responder_pkg.sv
// Shared DRP widths, responder state encoding and the captured-request record.
// Imported by the interface, the responder top and the bench.
package drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    typedef enum logic [3:0] {
        RSP_IDLE = 4'd0,
        RSP_BUSY = 4'd1,
        RSP_RESP = 4'd2,
        RSP_GAP  = 4'd3
    } drp_rsp_state_t;

    typedef struct packed {
        logic              we;
        logic [DRP_AW-1:0] addr;
        logic [DRP_DW-1:0] data;
    } drp_req_t;

endpackage

// File: rtl/mmcm_drp_responder_if.sv
// DRP bus between an initiator (master) and the emulated MMCM port (slave).
interface mmcm_drp_responder_if;
    import drp_pkg::*;

    logic              den;
    logic              dwe;
    logic [DRP_AW-1:0] daddr;
    logic [DRP_DW-1:0] din;
    logic [DRP_DW-1:0] dout;
    logic              drdy;

    modport master (output den, dwe, daddr, din, input dout, drdy);
    modport slave  (input den, dwe, daddr, din, output dout, drdy);

endinterface

// File: rtl/mmcm_drp_responder_lock.sv
// Emulated MMCM lock: saturating count of consecutive cycles with rst_mmcm low.
module mmcm_lock_model #(
    parameter int LOCK_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_mmcm,
    output logic locked
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rst_mmcm) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= (cnt_d == CNT_MAX);
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/mmcm_drp_responder.sv
// DRP target standing in for MMCM_ADV/PLL_ADV: 128x16 register bank with
// programmable drdy latency, sticky protocol-violation flag and a lock model.
module mmcm_drp_responder
    import drp_pkg::*;
#(
    parameter int              DRDY_LATENCY = 3,
    parameter int              LOCK_CYCLES  = 64,
    parameter logic [DRP_DW-1:0] INIT_VALUE = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    mmcm_drp_responder_if.slave  drp,
    input  logic                 rst_mmcm,
    output logic                 locked,
    output logic                 err
);

    localparam int BANK_DEPTH = 1 << DRP_AW;

    localparam logic [3:0] S_IDLE = RSP_IDLE;
    localparam logic [3:0] S_BUSY = RSP_BUSY;
    localparam logic [3:0] S_RESP = RSP_RESP;
    localparam logic [3:0] S_GAP  = RSP_GAP;

    localparam logic [3:0] LAT_M1 = 4'(DRDY_LATENCY - 1);

    logic [3:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    drp_req_t          req_q, req_d, req_in;
    logic              err_q, err_d;
    logic [DRP_DW-1:0] dout_q;
    logic              drdy_q;
    logic              resp_start;

    logic [BANK_DEPTH-1:0][DRP_DW-1:0] bank_q;

    assign req_in = {drp.dwe, drp.daddr, drp.din};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (drp.den) begin
                    req_d   = req_in;
                    cnt_d   = LAT_M1;
                    state_d = (LAT_M1 == 4'd0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                // Reads may be pulsed; a write must hold den with stable fields.
                if (drp.den && (req_in != req_q)) err_d = 1'b1;
                if (!drp.den && req_q.we)         err_d = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = S_RESP;
            end
            S_RESP: begin
                if (drp.den && (drp.daddr != req_q.addr)) err_d = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The response (and the bank write) is committed on the edge entering RESP,
    // so drdy and dout come straight from flops.
    assign resp_start = (state_d == S_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            drdy_q  <= 1'b0;
            bank_q  <= {BANK_DEPTH{INIT_VALUE}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            drdy_q  <= resp_start;
            if (resp_start) begin
                if (req_d.we) bank_q[req_d.addr] <= req_d.data;
                else          dout_q             <= bank_q[req_d.addr];
            end
        end
    end

    assign drp.dout = dout_q;
    assign drp.drdy = drdy_q;
    assign err      = err_q;

    mmcm_lock_model #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock (
        .clk      (clk),
        .reset    (reset),
        .rst_mmcm (rst_mmcm),
        .locked   (locked)
    );

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Bench for mmcm_drp_responder: timeline model of accepts/responses/lock on the
// main instance, plus directed literal checks on a latency-1 instance.
module tb_mmcm_drp_responder;
    import drp_pkg::*;

    localparam int LAT = 3;
    localparam int LC  = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_mmcm = 1'b1;
    logic locked, err;
    logic rst_mmcm1 = 1'b1;
    logic locked1, err1;

    mmcm_drp_responder_if drp();
    mmcm_drp_responder_if drp1();

    always #5 clk = ~clk;

    mmcm_drp_responder #(.DRDY_LATENCY(LAT), .LOCK_CYCLES(LC), .INIT_VALUE(16'h0000)) dut (
        .clk(clk), .reset(reset), .drp(drp), .rst_mmcm(rst_mmcm), .locked(locked), .err(err));

    mmcm_drp_responder #(.DRDY_LATENCY(1), .LOCK_CYCLES(1), .INIT_VALUE(16'h1234)) dut1 (
        .clk(clk), .reset(reset), .drp(drp1), .rst_mmcm(rst_mmcm1), .locked(locked1), .err(err1));

    int n_cmp = 0;
    int n_mis = 0;
    int n_print = 0;
    int drdy_cnt = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
            end
        end
    endfunction

    // Timeline model: accept at edge n if den and n >= next_acc; response at
    // edge n+LAT-1; next accept allowed LAT+2 edges after an accept.
    int          edge_n = 0;
    bit          mdl_on = 0;
    logic [15:0] m_bank [128];
    logic [15:0] m_dout;
    bit          m_drdy, m_err;
    int          last_one, next_acc;
    bit          cur_v, cur_we;
    int          cur_acc, cur_resp;
    logic [6:0]  cur_addr;
    logic [15:0] cur_data;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            mdl_on = 1;
            foreach (m_bank[i]) m_bank[i] = 16'h0000;
            m_dout = 16'h0000; m_drdy = 0; m_err = 0;
            last_one = edge_n; next_acc = edge_n + 1; cur_v = 0;
        end else if (mdl_on) begin
            m_drdy = 0;
            if (rst_mmcm) last_one = edge_n;
            if (cur_v) begin
                if (edge_n > cur_acc && edge_n <= cur_resp) begin
                    if (drp.den && (drp.dwe !== cur_we || drp.daddr !== cur_addr || drp.din !== cur_data)) m_err = 1;
                    if (!drp.den && cur_we) m_err = 1;
                end
                if (edge_n == cur_resp + 1 && drp.den && drp.daddr !== cur_addr) m_err = 1;
            end
            if (drp.den && edge_n >= next_acc) begin
                cur_v = 1; cur_acc = edge_n; cur_resp = edge_n + LAT - 1;
                cur_we = drp.dwe; cur_addr = drp.daddr; cur_data = drp.din;
                next_acc = edge_n + LAT + 2;
            end
            if (cur_v && edge_n == cur_resp) begin
                m_drdy = 1;
                if (cur_we) m_bank[cur_addr] = cur_data;
                else        m_dout = m_bank[cur_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            check("drdy", drp.drdy, m_drdy);
            check("dout", drp.dout, m_dout);
            check("err", err, m_err);
            check("locked", locked, (edge_n - last_one) >= LC);
            drdy_cnt += drp.drdy;
        end
    end

    // Called at a negedge with the responder idle; returns at a negedge ready for the next accept.
    task automatic xact(input bit we, input logic [6:0] a, input logic [15:0] d, input bit hold,
                        output logic [15:0] rd, output int lat);
        bit ok;
        ok = 0; rd = 16'h0; lat = 0;
        drp.den = 1; drp.dwe = we; drp.daddr = a; drp.din = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!hold) begin
                drp.den = 0; drp.dwe = 0;
                drp.daddr = 7'($urandom); drp.din = 16'($urandom);
            end
            if (drp.drdy) begin ok = 1; rd = drp.dout; lat = i + 1; end
        end
        if (!ok) begin
            n_cmp++; n_mis++;
            $display("FAIL drdy_timeout: no drdy for addr %0h within 20 cycles", a);
        end
        @(negedge clk);
        drp.den = 0; drp.dwe = 0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [15:0] s_val [23];
        int lat, cnt0;
        bit e_drdy [6];
        logic [6:0] e_addr [6];
        bit e_den [6];

        drp.den = 0; drp.dwe = 0; drp.daddr = '0; drp.din = '0;
        drp1.den = 0; drp1.dwe = 0; drp1.daddr = '0; drp1.din = '0;
        repeat (3) @(negedge clk);
        reset = 0;

        check("rst_dout", drp.dout, 16'h0);
        check("rst_drdy", drp.drdy, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err, 1'b0);

        // Pulsed read of 0x28: drdy in the cycle after accept+2, data = init.
        xact(0, 7'h28, 16'h0, 0, rd, lat);
        check("rd28_lat", lat, 32'd3);
        check("rd28_data", rd, 16'h0000);
        check("rd28_err", err, 1'b0);

        // Held write then read back; exactly one drdy for the held write.
        cnt0 = drdy_cnt;
        xact(1, 7'h08, 16'hA5C3, 1, rd, lat);
        check("wr08_single_drdy", drdy_cnt - cnt0, 32'd1);
        xact(0, 7'h08, 16'h0, 0, rd, lat);
        check("rd08_data", rd, 16'hA5C3);

        // 23-entry read-modify-write with rst_mmcm held high.
        for (int i = 0; i < 23; i++) begin
            s_val[i] = 16'($urandom) & 16'hFF00;
            xact(0, 7'(8'h40 + i), 16'h0, 0, rd, lat);
            xact(1, 7'(8'h40 + i), (rd & 16'h00FF) | s_val[i], 1, rd, lat);
            check("rmw_locked_low", locked, 1'b0);
        end
        for (int i = 0; i < 23; i++) begin
            xact(0, 7'(8'h40 + i), 16'h0, $urandom_range(0, 1), rd, lat);
            check("rmw_readback", rd, s_val[i]);
        end
        rst_mmcm = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 62) check("lock_not_yet", locked, 1'b0);
            if (i == 63) check("lock_at_64", locked, 1'b1);
        end

        // Random legal traffic with occasional rst_mmcm toggles.
        for (int t = 0; t < 60; t++) begin
            bit we;
            if ($urandom_range(0, 9) == 0) rst_mmcm = ~rst_mmcm;
            we = 1'($urandom_range(0, 1));
            xact(we, 7'($urandom_range(0, 15)), 16'($urandom), we ? 1'b1 : 1'($urandom_range(0, 1)), rd, lat);
            check("rand_lat", lat, 32'd3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("rand_no_err", err, 1'b0);
        rst_mmcm = 0;

        // Address changed during BUSY: sticky err, write still lands on 0x14.
        xact(1, 7'h15, 16'h1111, 1, rd, lat);
        drp.den = 1; drp.dwe = 1; drp.daddr = 7'h14; drp.din = 16'hBEEF;
        @(negedge clk);
        drp.daddr = 7'h15;
        repeat (LAT) @(negedge clk);
        drp.den = 0; drp.dwe = 0;
        @(negedge clk);
        check("err_set", err, 1'b1);
        xact(0, 7'h14, 16'h0, 0, rd, lat);
        check("err_rd14", rd, 16'hBEEF);
        xact(0, 7'h15, 16'h0, 0, rd, lat);
        check("err_rd15", rd, 16'h1111);
        check("err_sticky", err, 1'b1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("err_cleared", err, 1'b0);

        // Reset one cycle before a held write's drdy aborts the write.
        cnt0 = drdy_cnt;
        drp.den = 1; drp.dwe = 1; drp.daddr = 7'h30; drp.din = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0; drp.den = 0; drp.dwe = 0;
        repeat (4) @(negedge clk);
        check("abort_no_drdy", drdy_cnt - cnt0, 32'd0);
        xact(0, 7'h30, 16'h0, 0, rd, lat);
        check("abort_rd30", rd, 16'h0000);

        // Latency-1 instance: lock after one low cycle, spacing of 3 between accepts.
        check("l1_locked_low", locked1, 1'b0);
        rst_mmcm1 = 0;
        @(negedge clk);
        check("l1_locked_high", locked1, 1'b1);
        drp1.den = 1; drp1.dwe = 1; drp1.daddr = 7'h01; drp1.din = 16'h5678;
        @(negedge clk);
        check("l1_wr_drdy", drp1.drdy, 1'b1);
        drp1.den = 0; drp1.dwe = 0;
        @(negedge clk);
        check("l1_wr_drdy_single", drp1.drdy, 1'b0);
        @(negedge clk);
        e_den  = '{1, 1, 1, 1, 0, 0};
        e_addr = '{7'h00, 7'h00, 7'h01, 7'h01, 7'h00, 7'h00};
        e_drdy = '{1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drp1.den = e_den[i]; drp1.daddr = e_addr[i];
            @(negedge clk);
            check("l1_drdy", drp1.drdy, e_drdy[i]);
            if (i == 0) check("l1_dout00", drp1.dout, 16'h1234);
            if (i == 3) check("l1_dout01", drp1.dout, 16'h5678);
        end
        check("l1_err", err1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
